// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan sequencer.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the active-low pattern for hex digit n (index 15 first).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex_seg(nibble);

endmodule

// File: rtl/display_scan_sequencer.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value
// updates, inter-digit blanking and optional leading-zero suppression.
module display_scan_sequencer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 1000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        enable,
  input  logic        lz_blank,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_value,
  input  logic [7:0]  upd_dp,
  output logic [7:0]  anode_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int unsigned MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

  scan_state_t   state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   active_val_q, active_val_d;
  logic [7:0]    active_dp_q, active_dp_d;
  logic [31:0]   pend_val_q, pend_val_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          upd_ready_q, upd_ready_d;
  logic [7:0]    anode_n_q, anode_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;
  logic          frame_done_q, frame_done_d;

  logic          boundary;
  logic [3:0]    cur_nibble;
  logic [6:0]    dec_seg;
  logic [7:0]    lead_zero;

  // lead_zero[d]: nibbles NUM_DIGITS-1..d of the active value are all zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lead_zero
    if (gi == 0) begin : g_first
      assign lead_zero[gi] = 1'b0;
    end else if (gi >= NUM_DIGITS) begin : g_unused
      assign lead_zero[gi] = 1'b1;
    end else if (gi == 7) begin : g_top
      assign lead_zero[gi] = (active_val_q[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign lead_zero[gi] = lead_zero[gi+1] & (active_val_q[4*gi +: 4] == 4'h0);
    end
  end

  assign cur_nibble = active_val_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    upd_ready_d  = upd_ready_q;
    boundary     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A full pending buffer (ready low) drains at a frame boundary, or at once while stopped.
    if (!upd_ready_q && (boundary || !enable)) begin
      active_val_d = pend_val_q;
      active_dp_d  = pend_dp_q;
      upd_ready_d  = 1'b1;
    end
    if (upd_valid && upd_ready_q) begin
      pend_val_d  = upd_value;
      pend_dp_d   = upd_dp;
      upd_ready_d = 1'b0;
    end

    // Segments are presented during BLANK too, so they only switch while anodes are off.
    anode_n_d = 8'hFF;
    seg_n_d   = SEG_BLANK;
    dp_n_d    = 1'b1;
    if (state_q != IDLE) begin
      seg_n_d = (lz_blank && lead_zero[idx_q]) ? SEG_BLANK : dec_seg;
      dp_n_d  = ~active_dp_q[idx_q];
      if (state_q == DRIVE) begin
        anode_n_d = ~(8'h01 << idx_q);
      end
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      upd_ready_q  <= 1'b1;
      anode_n_q    <= 8'hFF;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      upd_ready_q  <= upd_ready_d;
      anode_n_q    <= anode_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ready  = upd_ready_q;
  assign anode_n    = anode_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer: a negedge monitor checks every
// lit-digit run against expectations queued when stimulus is applied.
module tb_display_scan_sequencer;

  localparam int N     = 4;
  localparam int TPD   = 4;
  localparam int BT    = 2;
  localparam int FRAME = N * (BT + TPD);

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        lz_blank = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_value = '0;
  logic [7:0]  upd_dp = '0;
  logic        upd_ready;
  logic [7:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  always #5 ACLK = ~ACLK;

  display_scan_sequencer #(
    .NUM_DIGITS      (N),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_value  (upd_value),
    .upd_dp     (upd_dp),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    int         len;   // 0 = run may be cut short, length not checked
    int         gap;   // 0 = preceding off time not checked
    logic       fd;
  } dig_t;

  dig_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   stray_fd = 0;
  bit   mon_on = 1'b0;

  always @(posedge ACLK) cyc++;

  function automatic logic [6:0] ref_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] val, input logic [7:0] dp, input bit lz,
                            input int first_gap, input int ndig, input int last_len);
    dig_t e;
    bit   lead;
    for (int d = 0; d < ndig; d++) begin
      lead = (d != 0);
      for (int k = d; k < N; k++) if (val[4*k +: 4] != 4'h0) lead = 1'b0;
      e.anode = ~(8'h01 << d);
      e.seg   = (lz && lead) ? 7'h7F : ref_seg(val[4*d +: 4]);
      e.dp    = ~dp[d];
      e.len   = (d == ndig - 1) ? last_len : TPD;
      e.gap   = (d == 0) ? first_gap : BT;
      e.fd    = (d == N - 1);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: each contiguous stretch of a lit anode is one digit run.
  bit         in_run = 1'b0;
  logic [7:0] run_anode;
  logic [6:0] run_seg, prev_seg = 7'h7F;
  logic       run_dp, prev_dp = 1'b1, last_fd;
  int         run_len, run_gap, run_fd, gap = 0;
  bit         run_bad;

  task automatic close_run();
    dig_t e;
    chk("digit_expected", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("digit_anode", run_anode, e.anode);
      chk("digit_seg", run_seg, e.seg);
      chk("digit_dp", run_dp, e.dp);
      chk("digit_stable", run_bad, 0);
      if (e.len != 0) chk("digit_len", run_len, e.len);
      if (e.gap != 0) chk("digit_gap", run_gap, e.gap);
      chk("digit_frame_done", {run_fd[30:0], last_fd}, e.fd ? 32'h3 : 32'h0);
    end
  endtask

  always @(negedge ACLK) begin
    if (mon_on) begin
      if (anode_n !== 8'hFF) begin
        if (!in_run) begin
          in_run    = 1'b1;
          run_anode = anode_n;
          run_seg   = seg_n;
          run_dp    = dp_n;
          run_len   = 0;
          run_gap   = gap;
          run_fd    = 0;
          run_bad   = (seg_n !== prev_seg) || (dp_n !== prev_dp);
        end else if (anode_n !== run_anode || seg_n !== run_seg || dp_n !== run_dp) begin
          run_bad = 1'b1;
        end
        run_len++;
        run_fd += (frame_done === 1'b1) ? 1 : 0;
        last_fd = (frame_done === 1'b1);
      end else begin
        if (frame_done !== 1'b0) stray_fd++;
        if (in_run) begin
          close_run();
          in_run = 1'b0;
          gap    = 0;
        end
        gap++;
      end
      prev_seg = seg_n;
      prev_dp  = dp_n;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_fd(input string tag, input int max);
    int k = 0;
    do begin step(1); k++; end while (frame_done !== 1'b1 && k < max);
    chk(tag, frame_done, 1'b1);
  endtask

  task automatic wait_anode(input string tag, input logic [7:0] val, input int max);
    int k = 0;
    while (anode_n !== val && k < max) begin step(1); k++; end
    chk(tag, anode_n, val);
  endtask

  // Enable is sampled on the first edge; the first anode is lit BT+1 cycles later.
  task automatic enable_and_time(input string tag);
    int n = 0;
    enable = 1'b1;
    do begin step(1); n++; end while (anode_n === 8'hFF && n < 40);
    chk({tag, "_latency"}, n, BT + 2);
    chk({tag, "_digit0"}, anode_n, 8'hFE);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_anode"}, anode_n, 8'hFF);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_dp"}, dp_n, 1'b1);
    chk({tag, "_ready"}, upd_ready, 1'b1);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    int t1;
    int k;

    step(3);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    step(3);
    chk("idle_anode", anode_n, 8'hFF);
    mon_on = 1'b1;

    // Frame 1 shows zeros; update accepted mid-frame appears from frame 2.
    push_frame(32'h0, 8'h0, 1'b0, 0, N, TPD);
    push_frame(32'h0000_12AF, 8'h02, 1'b0, BT, N, TPD);
    enable_and_time("start");
    step(5);
    chk("ready_idle", upd_ready, 1'b1);
    upd_valid = 1'b1;
    upd_value = 32'h0000_12AF;
    upd_dp    = 8'h02;
    step(1);
    upd_valid = 1'b0;
    upd_value = 32'hFFFF_FFFF;
    upd_dp    = 8'hFF;
    chk("ready_drop", upd_ready, 1'b0);
    wait_fd("frame1_done", 60);
    chk("ready_after_boundary", upd_ready, 1'b1);
    t1 = cyc;

    // Frame 2: queue two updates back to back; the second waits for the boundary.
    lz_blank = 1'b1;
    push_frame(32'h0000_0070, 8'h00, 1'b1, BT, N, TPD);
    push_frame(32'h0000_BE05, 8'hF5, 1'b1, BT, N, TPD);
    upd_valid = 1'b1;
    upd_value = 32'h0000_0070;
    upd_dp    = 8'h00;
    step(1);
    upd_value = 32'h0000_BE05;
    upd_dp    = 8'hF5;
    step(1);
    chk("ready_busy", upd_ready, 1'b0);
    k = 0;
    while (upd_ready !== 1'b1 && k < 60) begin step(1); k++; end
    chk("second_ready_at_boundary", frame_done, 1'b1);
    chk("frame_period", cyc - t1, FRAME);
    step(1);
    upd_valid = 1'b0;
    upd_value = 32'hDEAD_BEEF;
    chk("second_accepted", upd_ready, 1'b0);
    wait_fd("frame3_done", 60);
    chk("ready_after_second_swap", upd_ready, 1'b1);
    push_frame(32'h0000_BE05, 8'hF5, 1'b1, BT, 3, 0);
    wait_fd("frame4_done", 60);

    // Frame 5: drop enable while digit 2 is lit.
    wait_anode("reach_digit2", 8'hFB, 60);
    step(1);
    enable = 1'b0;
    step(2);
    chk("disable_anode", anode_n, 8'hFF);
    chk("disable_seg", seg_n, 7'h7F);
    chk("disable_dp", dp_n, 1'b1);
    push_frame(32'h0000_BE05, 8'hF5, 1'b1, 0, 2, 0);
    step(3);
    enable_and_time("restart");

    // Reset mid-frame with an update pending: it must be discarded.
    chk("ready_before_pend", upd_ready, 1'b1);
    upd_valid = 1'b1;
    upd_value = 32'h0000_5555;
    upd_dp    = 8'hFF;
    step(1);
    upd_valid = 1'b0;
    chk("pend_full", upd_ready, 1'b0);
    wait_anode("reach_digit1", 8'hFD, 40);
    ARESETN = 1'b0;
    enable  = 1'b0;
    step(1);
    check_reset_outputs("midframe_reset");
    step(2);
    ARESETN = 1'b1;
    step(2);
    push_frame(32'h0, 8'h00, 1'b1, 0, N, TPD);
    enable = 1'b1;
    wait_fd("post_reset_frame", 60);
    enable = 1'b0;
    chk("post_reset_ready", upd_ready, 1'b1);

    // While stopped, an accepted update drains to active on the next cycle.
    step(3);
    upd_valid = 1'b1;
    upd_value = 32'h0000_0C00;
    upd_dp    = 8'h08;
    step(1);
    upd_valid = 1'b0;
    chk("idle_accept", upd_ready, 1'b0);
    step(1);
    chk("idle_drain", upd_ready, 1'b1);
    push_frame(32'h0000_0C00, 8'h08, 1'b1, 0, N, TPD);
    enable = 1'b1;
    wait_fd("idle_update_frame", 60);
    enable = 1'b0;
    step(6);

    chk("scoreboard_drained", sb_q.size(), 0);
    chk("stray_frame_done", stray_fd, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
